// File: rtl/universal_shift_reg_if.sv
// rtl/universal_shift_reg_if.sv - control, data and status bundle for universal_shift_reg
interface universal_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_not;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] shift_cnt;
  logic             cnt_sat;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, q_not, sout_r, sout_l, shift_cnt, cnt_sat
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, q_not, sout_r, sout_l, shift_cnt, cnt_sat
  );
endinterface

// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - WIDTH-bit universal shift register with saturating shift counter
module universal_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);
  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_SHR    = 3'b001;
  localparam logic [2:0] MODE_SHL    = 3'b010;
  localparam logic [2:0] MODE_LOAD   = 3'b011;
  localparam logic [2:0] MODE_ROR    = 3'b100;
  localparam logic [2:0] MODE_ROL    = 3'b101;
  localparam logic [2:0] MODE_CLEAR  = 3'b110;
  localparam logic [2:0] MODE_PRESET = 3'b111;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
        MODE_SHR: begin
          q_next   = {bus.sin_r, q_reg[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_SHL: begin
          q_next   = {q_reg[WIDTH-2:0], bus.sin_l};
          cnt_next = cnt_inc;
        end
        MODE_LOAD: begin
          q_next   = bus.d;
          cnt_next = '0;
        end
        MODE_ROR: begin
          q_next   = {q_reg[0], q_reg[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_ROL: begin
          q_next   = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          cnt_next = cnt_inc;
        end
        MODE_CLEAR: begin
          q_next   = '0;
          cnt_next = '0;
        end
        MODE_PRESET: begin
          q_next   = RESET_VAL;
          cnt_next = '0;
        end
        // An unresolved mode falls through to hold.
        default: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg   <= RESET_VAL;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      cnt_reg <= cnt_next;
    end
  end

  assign bus.q         = q_reg;
  assign bus.q_not     = ~q_reg;
  assign bus.sout_r    = q_reg[0];
  assign bus.sout_l    = q_reg[WIDTH-1];
  assign bus.shift_cnt = cnt_reg;
  assign bus.cnt_sat   = (cnt_reg == {CNT_W{1'b1}});
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - directed self-checking bench for universal_shift_reg
module tb_universal_shift_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(8), .CNT_W(8)) a_if ();
  universal_shift_reg_if #(.WIDTH(8), .CNT_W(3)) b_if ();

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] m, input logic [7:0] dv, input logic sr, input logic sl);
    a_if.en    = 1'b1;
    a_if.mode  = m;
    a_if.d     = dv;
    a_if.sin_r = sr;
    a_if.sin_l = sl;
    step();
  endtask

  logic [7:0] shr_exp [3] = '{8'hC0, 8'hE0, 8'hF0};

  initial begin
    a_if.en = 1'b0; a_if.mode = 3'b000; a_if.d = '0; a_if.sin_r = 1'b0; a_if.sin_l = 1'b0;
    b_if.en = 1'b0; b_if.mode = 3'b000; b_if.d = '0; b_if.sin_r = 1'b0; b_if.sin_l = 1'b0;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b0;
    #1;
    check("rst_q", a_if.q, 8'hA5);
    check("rst_qn", a_if.q_not, 8'h5A);
    check("rst_cnt", a_if.shift_cnt, 0);
    check("rst_sout_r", a_if.sout_r, 1);
    check("rst_sout_l", a_if.sout_l, 1);
    check("rst_sat", a_if.cnt_sat, 0);
    a_if.en = 1'b1; a_if.mode = 3'b011; a_if.d = 8'hFF;
    step();
    check("rst_hold1", a_if.q, 8'hA5);
    step();
    check("rst_hold2", a_if.q, 8'hA5);
    rst = 1'b1;

    // Load then shift right with sin_r=1
    drive_a(3'b011, 8'h81, 1'b0, 1'b0);
    check("load81", a_if.q, 8'h81);
    check("load81_cnt", a_if.shift_cnt, 0);
    check("load81_sout_r", a_if.sout_r, 1);
    for (int i = 0; i < 3; i++) begin
      drive_a(3'b001, 8'h00, 1'b1, 1'b0);
      check($sformatf("shr%0d", i), a_if.q, shr_exp[i]);
      check($sformatf("shr%0d_sout_r", i), a_if.sout_r, shr_exp[i][0]);
    end
    check("shr_cnt", a_if.shift_cnt, 3);
    check("shr_sout_l", a_if.sout_l, 1);

    // Rotate left and right through a full cycle
    drive_a(3'b011, 8'h01, 1'b0, 1'b0);
    drive_a(3'b101, 8'h00, 1'b0, 1'b0);
    check("rol1", a_if.q, 8'h02);
    for (int i = 0; i < 7; i++) drive_a(3'b101, 8'h00, 1'b0, 1'b0);
    check("rol8", a_if.q, 8'h01);
    check("rol8_cnt", a_if.shift_cnt, 8);
    drive_a(3'b011, 8'h01, 1'b0, 1'b0);
    drive_a(3'b100, 8'h00, 1'b0, 1'b0);
    check("ror1", a_if.q, 8'h80);
    for (int i = 0; i < 7; i++) drive_a(3'b100, 8'h00, 1'b0, 1'b0);
    check("ror8", a_if.q, 8'h01);
    check("ror8_cnt", a_if.shift_cnt, 8);

    // Enable gating with a non-zero count
    drive_a(3'b011, 8'h78, 1'b0, 1'b0);
    drive_a(3'b001, 8'h00, 1'b0, 1'b0);
    check("pre_en_q", a_if.q, 8'h3C);
    a_if.en = 1'b0; a_if.mode = 3'b010; a_if.sin_l = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("en0_q", a_if.q, 8'h3C);
    check("en0_cnt", a_if.shift_cnt, 1);
    drive_a(3'b010, 8'h00, 1'b0, 1'b1);
    check("shl_q", a_if.q, 8'h79);
    check("shl_cnt", a_if.shift_cnt, 2);
    drive_a(3'b000, 8'h00, 1'b1, 1'b1);
    check("hold_q", a_if.q, 8'h79);
    check("hold_cnt", a_if.shift_cnt, 2);
    drive_a(3'b111, 8'h00, 1'b0, 1'b0);
    check("preset_q", a_if.q, 8'hA5);
    check("preset_cnt", a_if.shift_cnt, 0);
    drive_a(3'b110, 8'h00, 1'b0, 1'b0);
    check("clear_q", a_if.q, 8'h00);
    check("clear_qn", a_if.q_not, 8'hFF);

    // Reset in the middle of a shift-left run
    drive_a(3'b011, 8'h0F, 1'b0, 1'b0);
    drive_a(3'b010, 8'h00, 1'b0, 1'b0);
    drive_a(3'b010, 8'h00, 1'b0, 1'b0);
    check("mid_pre_q", a_if.q, 8'h3C);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_q", a_if.q, 8'hA5);
    check("mid_rst_cnt", a_if.shift_cnt, 0);
    #1 rst = 1'b1;
    drive_a(3'b010, 8'h00, 1'b0, 1'b1);
    check("mid_post_q", a_if.q, 8'h4B);
    check("mid_post_cnt", a_if.shift_cnt, 1);
    a_if.en = 1'b0;

    // Counter saturation on the 3-bit counter instance
    b_if.en = 1'b1; b_if.mode = 3'b110;
    step();
    check("b_clear_cnt", b_if.shift_cnt, 0);
    b_if.mode = 3'b010; b_if.sin_l = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("b_cnt%0d", k), b_if.shift_cnt, (k >= 7) ? 7 : k);
      check($sformatf("b_sat%0d", k), b_if.cnt_sat, (k >= 7) ? 1 : 0);
    end
    check("b_q_full", b_if.q, 8'hFF);
    b_if.mode = 3'b110;
    step();
    check("b_clear_q", b_if.q, 8'h00);
    check("b_clear_cnt2", b_if.shift_cnt, 0);
    check("b_clear_sat", b_if.cnt_sat, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
